// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings and op decode for the multiply/divide unit
package muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_FREE      = 2'd0,
        ST_WAITING   = 2'd1,
        ST_READY     = 2'd2,
        ST_EXECUTING = 2'd3
    } station_state_e;

    typedef enum logic [1:0] {
        ENG_IDLE = 2'd0,
        ENG_RUN  = 2'd1,
        ENG_DONE = 2'd2
    } engine_state_e;

    typedef struct packed {
        logic is_div;
        logic a_signed;
        logic b_signed;
        logic sel_hi;    // high product half for MULH*, remainder for REM*
    } op_decode_t;

    function automatic op_decode_t decode_op(input logic [2:0] op);
        op_decode_t d;
        d.is_div   = op[2];
        d.sel_hi   = op[2] ? op[1] : (op != OP_MUL);
        d.a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        d.b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        return d;
    endfunction

endpackage

// File: rtl/muldiv_engine.sv
// rtl/muldiv_engine.sv - iterative shift-add multiplier / restoring divider with start/done/accept handshake
module muldiv_engine
    import muldiv_pkg::*;
#(
    parameter int SIZE                 = 32,
    parameter int ITERATIONS_PER_CYCLE = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [SIZE-1:0] a_i,
    input  logic [SIZE-1:0] b_i,
    input  logic            accept_i,
    output logic            idle_o,
    output logic            done_o,
    output logic [SIZE-1:0] result_o
);

    localparam int STEPS = SIZE / ITERATIONS_PER_CYCLE;
    localparam int CNT_W = $clog2(STEPS + 1);

    engine_state_e   state_q, state_d;
    logic [SIZE-1:0] hi_q, lo_q, b_q, result_q;
    logic            div_q, neg_q, sel_q;
    logic [CNT_W-1:0] cnt_q;

    op_decode_t      dec;
    logic            a_neg, b_neg, div_zero, last_step;
    logic [SIZE-1:0] a_mag, b_mag;

    always_comb begin
        dec      = decode_op(op_i);
        a_neg    = dec.a_signed & a_i[SIZE-1];
        b_neg    = dec.b_signed & b_i[SIZE-1];
        a_mag    = a_neg ? -a_i : a_i;
        b_mag    = b_neg ? -b_i : b_i;
        div_zero = dec.is_div && (b_i == '0);
    end

    assign last_step = (cnt_q == CNT_W'(STEPS - 1));

    // hi holds the partial product high half or the partial remainder; lo the multiplier or quotient bits
    logic [SIZE-1:0]   hi_n, lo_n, half_t, res_n;
    logic [SIZE:0]     rem_t, sum_t;
    logic [2*SIZE-1:0] full_t;

    always_comb begin
        hi_n  = hi_q;
        lo_n  = lo_q;
        rem_t = '0;
        sum_t = '0;
        for (int k = 0; k < ITERATIONS_PER_CYCLE; k++) begin
            if (div_q) begin
                rem_t = {hi_n, lo_n[SIZE-1]};
                lo_n  = {lo_n[SIZE-2:0], 1'b0};
                if (rem_t >= {1'b0, b_q}) begin
                    rem_t   = rem_t - {1'b0, b_q};
                    lo_n[0] = 1'b1;
                end
                hi_n = rem_t[SIZE-1:0];
            end else begin
                sum_t = {1'b0, hi_n} + (lo_n[0] ? {1'b0, b_q} : {(SIZE+1){1'b0}});
                lo_n  = {sum_t[0], lo_n[SIZE-1:1]};
                hi_n  = sum_t[SIZE:1];
            end
        end
        full_t = {hi_n, lo_n};
        if (!div_q && neg_q) begin
            full_t = -full_t;
        end
        half_t = sel_q ? full_t[2*SIZE-1:SIZE] : full_t[SIZE-1:0];
        res_n  = (div_q && neg_q) ? -half_t : half_t;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ENG_IDLE: if (start_i) state_d = div_zero ? ENG_DONE : ENG_RUN;
            ENG_RUN:  if (last_step) state_d = ENG_DONE;
            ENG_DONE: if (accept_i) state_d = ENG_IDLE;
            default:  state_d = ENG_IDLE;
        endcase
        if (flush_i) begin
            state_d = ENG_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ENG_IDLE;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            result_q <= '0;
            div_q    <= 1'b0;
            neg_q    <= 1'b0;
            sel_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            if (!flush_i && state_q == ENG_IDLE && start_i) begin
                hi_q  <= '0;
                lo_q  <= a_mag;
                b_q   <= b_mag;
                div_q <= dec.is_div;
                sel_q <= dec.sel_hi;
                neg_q <= (dec.is_div && dec.sel_hi) ? a_neg : (a_neg ^ b_neg);
                cnt_q <= '0;
                if (div_zero) begin
                    result_q <= dec.sel_hi ? a_i : '1;
                end
            end else if (!flush_i && state_q == ENG_RUN) begin
                hi_q  <= hi_n;
                lo_q  <= lo_n;
                cnt_q <= cnt_q + CNT_W'(1);
                if (last_step) begin
                    result_q <= res_n;
                end
            end
        end
    end

    assign idle_o   = (state_q == ENG_IDLE);
    assign done_o   = (state_q == ENG_DONE);
    assign result_o = result_q;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - reservation stations, bus snooping and round-robin issue into the shared engine
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int SIZE                 = 32,
    parameter int ITERATIONS_PER_CYCLE = 4,
    parameter int STATION_COUNT        = 2,
    parameter int TAG_SIZE             = 4,
    parameter int BUS_COUNT            = 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          flush_i,
    input  logic                          issue_valid_i,
    output logic                          issue_ready_o,
    input  logic [2:0]                    issue_op_i,
    input  logic [TAG_SIZE-1:0]           issue_tag_i,
    input  logic                          a_preload_i,
    input  logic                          b_preload_i,
    input  logic [TAG_SIZE-1:0]           a_source_i,
    input  logic [TAG_SIZE-1:0]           b_source_i,
    input  logic [SIZE-1:0]               a_value_i,
    input  logic [SIZE-1:0]               b_value_i,
    input  logic [BUS_COUNT-1:0]          bus_asserted_i,
    input  logic [BUS_COUNT*TAG_SIZE-1:0] bus_source_i,
    input  logic [BUS_COUNT*SIZE-1:0]     bus_value_i,
    output logic                          result_valid_o,
    output logic [TAG_SIZE-1:0]           result_tag_o,
    output logic [SIZE-1:0]               result_value_o,
    input  logic                          result_accept_i,
    output logic [STATION_COUNT-1:0]      station_busy_o
);

    localparam int IDX_W = (STATION_COUNT > 1) ? $clog2(STATION_COUNT) : 1;

    typedef struct packed {
        station_state_e      state;
        logic [2:0]          op;
        logic [TAG_SIZE-1:0] tag;
        logic                a_ok;
        logic                b_ok;
        logic [TAG_SIZE-1:0] a_src;
        logic [TAG_SIZE-1:0] b_src;
        logic [SIZE-1:0]     a_val;
        logic [SIZE-1:0]     b_val;
    } station_t;

    station_t            st_q [STATION_COUNT];
    station_t            st_d [STATION_COUNT];
    logic [IDX_W-1:0]    last_q, exec_q;
    logic [TAG_SIZE-1:0] tag_q;

    logic             eng_idle, eng_done;
    logic [SIZE-1:0]  eng_result;
    logic             alloc_valid, grant_valid;
    logic [IDX_W-1:0] alloc_idx, grant_idx;
    logic             issue_fire, grant_fire, accept_fire;
    logic [SIZE:0]    a_hit, b_hit, snoop_t;

    // Returns {hit, value} from the lowest-index bus carrying the requested producer tag
    function automatic logic [SIZE:0] snoop(
        input logic [TAG_SIZE-1:0]           src,
        input logic [BUS_COUNT-1:0]          asserted,
        input logic [BUS_COUNT*TAG_SIZE-1:0] sources,
        input logic [BUS_COUNT*SIZE-1:0]     values
    );
        logic [SIZE:0] r;
        r = '0;
        for (int k = BUS_COUNT - 1; k >= 0; k--) begin
            if (asserted[k] && sources[k*TAG_SIZE +: TAG_SIZE] == src) begin
                r = {1'b1, values[k*SIZE +: SIZE]};
            end
        end
        return r;
    endfunction

    always_comb begin
        alloc_valid = 1'b0;
        alloc_idx   = '0;
        for (int i = STATION_COUNT - 1; i >= 0; i--) begin
            if (st_q[i].state == ST_FREE) begin
                alloc_valid = 1'b1;
                alloc_idx   = IDX_W'(i);
            end
        end
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = 1; i <= STATION_COUNT; i++) begin
            if (!grant_valid && st_q[(int'(last_q) + i) % STATION_COUNT].state == ST_READY) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'((int'(last_q) + i) % STATION_COUNT);
            end
        end
    end

    assign issue_fire  = issue_valid_i && alloc_valid && !flush_i;
    assign grant_fire  = eng_idle && grant_valid && !flush_i;
    assign accept_fire = eng_done && result_accept_i && !flush_i;

    always_comb begin
        a_hit   = snoop(a_source_i, bus_asserted_i, bus_source_i, bus_value_i);
        b_hit   = snoop(b_source_i, bus_asserted_i, bus_source_i, bus_value_i);
        snoop_t = '0;
        for (int i = 0; i < STATION_COUNT; i++) begin
            st_d[i] = st_q[i];
            if (st_q[i].state == ST_WAITING) begin
                if (!st_q[i].a_ok) begin
                    snoop_t = snoop(st_q[i].a_src, bus_asserted_i, bus_source_i, bus_value_i);
                    if (snoop_t[SIZE]) begin
                        st_d[i].a_ok  = 1'b1;
                        st_d[i].a_val = snoop_t[SIZE-1:0];
                    end
                end
                if (!st_q[i].b_ok) begin
                    snoop_t = snoop(st_q[i].b_src, bus_asserted_i, bus_source_i, bus_value_i);
                    if (snoop_t[SIZE]) begin
                        st_d[i].b_ok  = 1'b1;
                        st_d[i].b_val = snoop_t[SIZE-1:0];
                    end
                end
                if (st_d[i].a_ok && st_d[i].b_ok) begin
                    st_d[i].state = ST_READY;
                end
            end
        end
        if (grant_fire) begin
            st_d[grant_idx].state = ST_EXECUTING;
        end
        if (accept_fire) begin
            st_d[exec_q].state = ST_FREE;
        end
        if (issue_fire) begin
            st_d[alloc_idx].op    = issue_op_i;
            st_d[alloc_idx].tag   = issue_tag_i;
            st_d[alloc_idx].a_src = a_source_i;
            st_d[alloc_idx].b_src = b_source_i;
            st_d[alloc_idx].a_ok  = a_preload_i || a_hit[SIZE];
            st_d[alloc_idx].b_ok  = b_preload_i || b_hit[SIZE];
            st_d[alloc_idx].a_val = a_preload_i ? a_value_i : a_hit[SIZE-1:0];
            st_d[alloc_idx].b_val = b_preload_i ? b_value_i : b_hit[SIZE-1:0];
            st_d[alloc_idx].state = (st_d[alloc_idx].a_ok && st_d[alloc_idx].b_ok) ? ST_READY : ST_WAITING;
        end
        if (flush_i) begin
            for (int i = 0; i < STATION_COUNT; i++) begin
                st_d[i].state = ST_FREE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < STATION_COUNT; i++) begin
                st_q[i] <= '0;
            end
            last_q <= IDX_W'(STATION_COUNT - 1);
            exec_q <= '0;
            tag_q  <= '0;
        end else begin
            for (int i = 0; i < STATION_COUNT; i++) begin
                st_q[i] <= st_d[i];
            end
            if (grant_fire) begin
                last_q <= grant_idx;
                exec_q <= grant_idx;
                tag_q  <= st_q[grant_idx].tag;
            end
        end
    end

    muldiv_engine #(
        .SIZE                 (SIZE),
        .ITERATIONS_PER_CYCLE (ITERATIONS_PER_CYCLE)
    ) u_engine (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .flush_i  (flush_i),
        .start_i  (grant_fire),
        .op_i     (st_q[grant_idx].op),
        .a_i      (st_q[grant_idx].a_val),
        .b_i      (st_q[grant_idx].b_val),
        .accept_i (result_accept_i),
        .idle_o   (eng_idle),
        .done_o   (eng_done),
        .result_o (eng_result)
    );

    always_comb begin
        for (int i = 0; i < STATION_COUNT; i++) begin
            station_busy_o[i] = (st_q[i].state != ST_FREE);
        end
    end

    assign issue_ready_o  = alloc_valid;
    assign result_valid_o = eng_done;
    assign result_tag_o   = tag_q;
    assign result_value_o = eng_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        issue_valid;
    logic        issue_ready;
    logic [2:0]  issue_op;
    logic [3:0]  issue_tag;
    logic        a_preload, b_preload;
    logic [3:0]  a_source, b_source;
    logic [31:0] a_value, b_value;
    logic [0:0]  bus_asserted;
    logic [3:0]  bus_source;
    logic [31:0] bus_value;
    logic        result_valid;
    logic [3:0]  result_tag;
    logic [31:0] result_value;
    logic        result_accept;
    logic [1:0]  station_busy;

    int tests = 0;
    int fails = 0;

    muldiv_unit dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .flush_i         (flush),
        .issue_valid_i   (issue_valid),
        .issue_ready_o   (issue_ready),
        .issue_op_i      (issue_op),
        .issue_tag_i     (issue_tag),
        .a_preload_i     (a_preload),
        .b_preload_i     (b_preload),
        .a_source_i      (a_source),
        .b_source_i      (b_source),
        .a_value_i       (a_value),
        .b_value_i       (b_value),
        .bus_asserted_i  (bus_asserted),
        .bus_source_i    (bus_source),
        .bus_value_i     (bus_value),
        .result_valid_o  (result_valid),
        .result_tag_o    (result_tag),
        .result_value_o  (result_value),
        .result_accept_i (result_accept),
        .station_busy_o  (station_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = {32'b0, a};
        longint unsigned ub = {32'b0, b};
        logic [63:0]     p;
        logic            ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Caller is at a negedge; returns at the negedge after the issue edge
    task automatic issue(input logic [2:0] op, input logic [3:0] tag,
                         input logic apre, input logic [3:0] asrc, input logic [31:0] aval,
                         input logic bpre, input logic [3:0] bsrc, input logic [31:0] bval);
        issue_valid = 1'b1;
        issue_op    = op;
        issue_tag   = tag;
        a_preload   = apre;
        a_source    = asrc;
        a_value     = aval;
        b_preload   = bpre;
        b_source    = bsrc;
        b_value     = bval;
        @(negedge clk);
        issue_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!result_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!result_valid) begin
            tests++;
            fails++;
            $display("FAIL wait_valid: timeout after %0d cycles, result_valid stays 0", n);
        end
    endtask

    task automatic accept();
        result_accept = 1'b1;
        @(negedge clk);
        result_accept = 1'b0;
    endtask

    task automatic bus_pulse(input logic [3:0] src, input logic [31:0] val);
        bus_asserted = 1'b1;
        bus_source   = src;
        bus_value    = val;
        @(negedge clk);
        bus_asserted = 1'b0;
    endtask

    // Two ops wait on the same producer so they become READY together; returns tags in completion order
    task automatic rr_pair(input logic [3:0] t0, input logic [3:0] t1, output logic [3:0] first, output logic [3:0] second);
        int n;
        issue(3'd0, t0, 1'b0, 4'd9, 32'd0, 1'b1, 4'd0, 32'd2);
        issue(3'd0, t1, 1'b0, 4'd9, 32'd0, 1'b1, 4'd0, 32'd3);
        bus_pulse(4'd9, 32'd11);
        wait_valid(n);
        first = result_tag;
        check("rr_first_value", result_value, (t0 == first) ? 32'd22 : 32'd33);
        accept();
        wait_valid(n);
        second = result_tag;
        check("rr_second_value", result_value, (t0 == second) ? 32'd22 : 32'd33);
        accept();
    endtask

    vec_t vecs[14];

    initial begin
        int          n;
        logic        stable, seen;
        logic [3:0]  f, s, rtag;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        vecs[0]  = '{3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 9};
        vecs[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 9};
        vecs[2]  = '{3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 9};
        vecs[3]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 9};
        vecs[4]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 9};
        vecs[5]  = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
        vecs[6]  = '{3'd6, 32'd5,         32'd0,         32'd5,         1};
        vecs[7]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 9};
        vecs[8]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         9};
        vecs[9]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 9};
        vecs[10] = '{3'd5, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 9};
        vecs[11] = '{3'd7, 32'd100,       32'd7,         32'd2,         9};
        vecs[12] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         9};
        vecs[13] = '{3'd4, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 1};

        rst_n = 1'b0; flush = 1'b0; issue_valid = 1'b0; issue_op = '0; issue_tag = '0;
        a_preload = 1'b0; b_preload = 1'b0; a_source = '0; b_source = '0; a_value = '0; b_value = '0;
        bus_asserted = '0; bus_source = '0; bus_value = '0; result_accept = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_valid", {31'b0, result_valid}, 32'd0);
        check("reset_tag", {28'b0, result_tag}, 32'd0);
        check("reset_value", result_value, 32'd0);
        check("reset_busy", {30'b0, station_busy}, 32'd0);
        check("reset_ready", {31'b0, issue_ready}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            issue(vecs[i].op, 4'(i + 1), 1'b1, 4'd0, vecs[i].a, 1'b1, 4'd0, vecs[i].b);
            wait_valid(n);
            check($sformatf("vec%0d_value", i), result_value, vecs[i].exp);
            check($sformatf("vec%0d_tag", i), {28'b0, result_tag}, 32'(i + 1));
            check($sformatf("vec%0d_latency", i), 32'(n), 32'(vecs[i].lat));
            accept();
        end

        // operand forwarding: a captured in the issue cycle, b four cycles later
        bus_asserted = 1'b1; bus_source = 4'd3; bus_value = 32'd10;
        issue(3'd0, 4'd1, 1'b0, 4'd3, 32'd0, 1'b1, 4'd0, 32'd5);
        bus_asserted = 1'b0;
        issue(3'd4, 4'd2, 1'b1, 4'd0, 32'd100, 1'b0, 4'd6, 32'd0);
        check("fwd_busy", {30'b0, station_busy}, 32'd3);
        repeat (3) @(negedge clk);
        bus_pulse(4'd6, 32'd7);
        wait_valid(n);
        check("fwd_tag1", {28'b0, result_tag}, 32'd1);
        check("fwd_val1", result_value, 32'd50);
        accept();
        wait_valid(n);
        check("fwd_tag2", {28'b0, result_tag}, 32'd2);
        check("fwd_val2", result_value, 32'd14);
        accept();

        // backpressure with both stations occupied
        issue(3'd0, 4'd5, 1'b1, 4'd0, 32'd3, 1'b1, 4'd0, 32'd4);
        issue(3'd5, 4'd6, 1'b1, 4'd0, 32'd100, 1'b1, 4'd0, 32'd3);
        wait_valid(n);
        check("bp_tag", {28'b0, result_tag}, 32'd5);
        check("bp_value", result_value, 32'd12);
        check("bp_ready_full", {31'b0, issue_ready}, 32'd0);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!(result_valid && result_value == 32'd12 && result_tag == 4'd5)) stable = 1'b0;
        end
        check("bp_stable", {31'b0, stable}, 32'd1);
        accept();
        check("bp_valid_drop", {31'b0, result_valid}, 32'd0);
        check("bp_busy_after", {30'b0, station_busy}, 32'd2);
        check("bp_ready_after", {31'b0, issue_ready}, 32'd1);
        wait_valid(n);
        check("bp_second_latency", 32'(n), 32'd9);
        check("bp_second_tag", {28'b0, result_tag}, 32'd6);
        check("bp_second_value", result_value, 32'd33);
        accept();

        // round robin: last grant was station 1, so station 0 wins first
        rr_pair(4'd7, 4'd8, f, s);
        check("rr_a_first", {28'b0, f}, 32'd7);
        check("rr_a_second", {28'b0, s}, 32'd8);
        issue(3'd3, 4'd10, 1'b1, 4'd0, 32'h0001_0000, 1'b1, 4'd0, 32'h0001_0000);
        wait_valid(n);
        check("rr_single", result_value, 32'd1);
        accept();
        rr_pair(4'd11, 4'd12, f, s);
        check("rr_b_first", {28'b0, f}, 32'd12);
        check("rr_b_second", {28'b0, s}, 32'd11);

        for (int i = 0; i < 40; i++) begin
            rop  = 3'($urandom_range(0, 7));
            rtag = 4'($urandom);
            ra   = $urandom;
            rb   = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 20));
                3: ra = 32'h8000_0000;
                default: ;
            endcase
            issue(rop, rtag, 1'b1, 4'd0, ra, 1'b1, 4'd0, rb);
            wait_valid(n);
            check($sformatf("rand%0d op%0d %h,%h", i, rop, ra, rb), result_value, ref_result(rop, ra, rb));
            check($sformatf("rand%0d_tag", i), {28'b0, result_tag}, {28'b0, rtag});
            accept();
        end

        // flush during RUN with both stations occupied
        issue(3'd0, 4'd1, 1'b1, 4'd0, 32'd9, 1'b1, 4'd0, 32'd9);
        issue(3'd0, 4'd2, 1'b1, 4'd0, 32'd8, 1'b1, 4'd0, 32'd8);
        repeat (3) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", {30'b0, station_busy}, 32'd0);
        check("flush_valid", {31'b0, result_valid}, 32'd0);
        check("flush_ready", {31'b0, issue_ready}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (result_valid) seen = 1'b1;
        end
        check("flush_no_result", {31'b0, seen}, 32'd0);

        // asynchronous reset mid-RUN
        issue(3'd0, 4'd9, 1'b1, 4'd0, 32'd6, 1'b1, 4'd0, 32'd7);
        wait_valid(n);
        check("pre_reset_value", result_value, 32'd42);
        accept();
        issue(3'd0, 4'd3, 1'b1, 4'd0, 32'd5, 1'b1, 4'd0, 32'd5);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("areset_valid", {31'b0, result_valid}, 32'd0);
        check("areset_tag", {28'b0, result_tag}, 32'd0);
        check("areset_value", result_value, 32'd0);
        check("areset_busy", {30'b0, station_busy}, 32'd0);
        check("areset_ready", {31'b0, issue_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-station iterative multiply/divide functional unit for the out-of-order core. It holds up to STATION_COUNT pending RV32M operations, snoops the result buses for missing operands, and issues ready operations to one shared radix-2^k engine. Completed results go to the bus arbiter through a valid/accept handshake. It replaces the single-station multiplier and adds full M-extension coverage, remainders, and divide-by-zero semantics.

## Interface
- SIZE, 32, operand/result width
- ITERATIONS_PER_CYCLE, 4, engine bits processed per cycle; must divide SIZE
- STATION_COUNT, 2, reservation stations (≥1)
- TAG_SIZE, 4, width of global station tags carried on buses
- BUS_COUNT, 1, result buses snooped
- clock  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- flush  in  1  synchronous; discard every station and abort the engine
- issue_valid  in  1  new operation offered
- issue_ready  out  1  at least one station FREE
- issue_op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- issue_tag  in  TAG_SIZE  tag under which the result is broadcast
- a_preload, b_preload  in  1 each  operand value is valid now
- a_source, b_source  in  TAG_SIZE each  producer tag when not preloaded
- a_value, b_value  in  SIZE each  preloaded values
- bus_asserted  in  BUS_COUNT  per-bus valid
- bus_source  in  BUS_COUNT*TAG_SIZE  per-bus producer tag, flattened
- bus_value  in  BUS_COUNT*SIZE  per-bus value, flattened
- result_valid  out  1  registered; result held stable until accepted
- result_tag  out  TAG_SIZE  tag of the completed operation
- result_value  out  SIZE  result
- result_accept  in  1  arbiter takes the result this cycle
- station_busy  out  STATION_COUNT  per-station occupancy, for debug and stall logic

## Operation
- Station states: FREE → WAITING (an operand is missing) or READY → EXECUTING → FREE.
- Issue: issue_valid && issue_ready && !flush allocates the lowest-index FREE station.
- Operand capture: a WAITING operand takes the value from the lowest-index bus with bus_asserted and a matching source. This includes the issue cycle, so a bus match in the issue cycle loads the operand directly.
- Engine FSM: IDLE → RUN → DONE → IDLE.
  - In IDLE, grant goes round-robin among READY stations, starting after the last granted index.
  - In DONE, result_accept returns the engine to IDLE and frees the station.
- Setup at grant: latch the operand magnitudes, the result sign, and the selected half.
  - MULH: both operands signed. MULHSU: a signed, b unsigned. Others per the U suffix.
- Multiply: unsigned shift-add over SIZE bits of magnitudes into a 2*SIZE product, negated if the signs differ. MUL returns the low half; MULH* return the high half.
- Divide: restoring division over SIZE bits.
  - Quotient sign = sign(a) xor sign(b). Remainder sign = sign(a).
- Divide by zero skips RUN and goes straight to DONE: quotient all ones, remainder = a (signed and unsigned).
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0. This falls out of the algorithm with no special case.
- Flush clears all stations to FREE, returns the engine to IDLE, and drops result_valid. Flush has priority over issue, capture and accept in the same cycle.

## Timing
- Reset values: result_valid 0, result_tag 0, result_value 0, station_busy 0, issue_ready 1.
- A station with both operands preloaded is READY the cycle after issue. It may be granted that cycle if the engine is IDLE.
- Latency from grant: grant edge, then SIZE/ITERATIONS_PER_CYCLE RUN cycles, then result_valid. For 32/4 that is 8 RUN cycles, so result_valid appears 9 cycles after the grant cycle.
- Divide-by-zero: result_valid is asserted the cycle after grant.
- Result stall: result_valid may stay high indefinitely. No new grant is made while in DONE.
- Accept/grant spacing: grant can occur the cycle after accept. No overlap.
- Freed-station reuse: a station freed by accept is reported in issue_ready starting the next cycle.
- Reset mid-operation: takes effect asynchronously and discards everything.

## Structure
- Package muldiv_pkg contains:
  - operation funct3 constants
  - station-state encoding
  - engine-state encoding
  - helper for the is_divide/is_signed decode
- Sub-module muldiv_engine contains the setup, RUN iteration loop and DONE result register. It has a start/done/accept handshake and no knowledge of stations or tags.
- The top level holds the station array, bus snooping, round-robin arbiter and flush handling.

## Test plan
- MUL 7×−3, both operands preloaded → result 0xFFFFFFEB, tag echoed, result_valid 9 cycles after grant.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD. REM −7/2 → 0xFFFFFFFF. DIVU 5/0 → 0xFFFFFFFF, one cycle after grant. REM 5/0 → 5. DIV 0x80000000/−1 → 0x80000000.
- Operand forwarding: issue with a from tag 3, and bus 0 carries tag 3 = 10 in the issue cycle. Issue a second op whose b arrives 4 cycles later. Both capture their operands and complete in round-robin order.
- Backpressure: hold result_accept low for 20 cycles with both stations READY. result_value stays stable, the second op starts the cycle after accept, and issue_ready follows station occupancy.
- Flush during RUN with both stations occupied → all station_busy 0 and result_valid 0 next cycle. No result emerges. Assert reset mid-RUN → outputs at reset values immediately.
